// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and handshake FSM states.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_MUL = 2'b01,
      OP_SUB = 2'b10,
      OP_DIV = 2'b11
   } opcode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_seq_muldiv_core.sv
// W-iteration datapath: shift-add multiply (LSB first) and restoring divide (MSB first).
// Both leave their 2W-bit result in {hi, lo}: product, or {remainder, quotient}.
module seq_muldiv_core #(
   parameter int W  = 8,
   parameter int CW = $clog2(W) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           step,
   input  logic           is_div,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           last,
   output logic [2*W-1:0] result,
   output logic           dz
);

   logic [W-1:0]  hi, lo, m;
   logic [W-1:0]  hi_n, lo_n;
   logic [W:0]    acc, t;
   logic          div_r, dz_r;
   logic [CW-1:0] cnt;

   always_comb begin
      hi_n = hi;
      lo_n = lo;
      acc  = '0;
      t    = '0;
      if (div_r) begin
         // A zero divisor always "fits": quotient fills with ones and A shifts into hi.
         t = {hi, lo[W-1]};
         if (t >= {1'b0, m}) begin
            hi_n = t[W-1:0] - m;
            lo_n = {lo[W-2:0], 1'b1};
         end else begin
            hi_n = t[W-1:0];
            lo_n = {lo[W-2:0], 1'b0};
         end
      end else begin
         acc  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
         hi_n = acc[W:1];
         lo_n = {acc[0], lo[W-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi    <= '0;
         lo    <= '0;
         m     <= '0;
         div_r <= 1'b0;
         dz_r  <= 1'b0;
         cnt   <= '0;
      end else if (load) begin
         hi    <= '0;
         lo    <= is_div ? a : b;
         m     <= is_div ? b : a;
         div_r <= is_div;
         dz_r  <= is_div && (b == '0);
         cnt   <= '0;
      end else if (step) begin
         hi    <= hi_n;
         lo    <= lo_n;
         cnt   <= cnt + CW'(1);
      end
   end

   assign last   = (cnt == CW'(W - 1));
   assign result = {hi_n, lo_n};
   assign dz     = dz_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB, W-cycle MUL/DIV, start/busy/done handshake
// with a registered result and divide-by-zero flag held until the next completion.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   portA,
   input  logic [W-1:0]   portB,
   input  logic [1:0]     opcode,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] out,
   output logic           err
);

   localparam int CW = $clog2(W) + 1;

   state_t         state, state_n;
   logic [2*W-1:0] out_n, md_res;
   logic           err_n, done_n;
   logic           load, step, last, dz;
   logic [W:0]     sum, diff;

   assign sum  = {1'b0, portA} + {1'b0, portB};
   assign diff = {1'b0, portA} - {1'b0, portB};

   seq_muldiv_core #(.W(W), .CW(CW)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .is_div (opcode_t'(opcode) == OP_DIV),
      .a      (portA),
      .b      (portB),
      .last   (last),
      .result (md_res),
      .dz     (dz)
   );

   always_comb begin
      state_n = state;
      out_n   = out;
      err_n   = err;
      done_n  = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               case (opcode_t'(opcode))
                  OP_ADD: begin
                     out_n  = {{(W-1){1'b0}}, sum};
                     err_n  = 1'b0;
                     done_n = 1'b1;
                  end
                  OP_SUB: begin
                     out_n  = {{(W-1){1'b0}}, diff};
                     err_n  = 1'b0;
                     done_n = 1'b1;
                  end
                  default: begin
                     load    = 1'b1;
                     state_n = RUN;
                  end
               endcase
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               out_n   = md_res;
               err_n   = dz;
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         out   <= '0;
         err   <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         out   <= out_n;
         err   <= err_n;
         done  <= done_n;
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at W=8 and W=3 with directed, hand-computed vectors.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  a8, b8;
   logic [1:0]  op8;
   logic        st8, busy8, done8, err8;
   logic [15:0] out8;
   logic [2:0]  a3, b3;
   logic [1:0]  op3;
   logic        st3, busy3, done3, err3;
   logic [5:0]  out3;

   always #5 clk = ~clk;

   alu_seq #(.W(8)) dut8 (
      .clk(clk), .rst(rst), .portA(a8), .portB(b8), .opcode(op8), .start(st8),
      .busy(busy8), .done(done8), .out(out8), .err(err8)
   );

   alu_seq #(.W(3)) dut3 (
      .clk(clk), .rst(rst), .portA(a3), .portB(b3), .opcode(op3), .start(st3),
      .busy(busy3), .done(done3), .out(out3), .err(err3)
   );

   typedef struct {
      logic [15:0] out;
      logic        err;
      int unsigned at;
   } exp_t;

   exp_t        q8[$];
   exp_t        q3[$];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon8
      exp_t e;
      if (done8 === 1'b1) begin
         if (q8.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done8: got done with out=%0h, expected no done", out8);
         end else begin
            e = q8.pop_front();
            check("out8", {16'h0, out8}, {16'h0, e.out});
            check("err8", {31'h0, err8}, {31'h0, e.err});
            check("latency8", cyc, e.at);
         end
      end
   end

   always @(negedge clk) begin : mon3
      exp_t e;
      if (done3 === 1'b1) begin
         if (q3.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done3: got done with out=%0h, expected no done", out3);
         end else begin
            e = q3.pop_front();
            check("out3", {26'h0, out3}, {16'h0, e.out});
            check("err3", {31'h0, err3}, {31'h0, e.err});
            check("latency3", cyc, e.at);
         end
      end
   end

   // Called at a negedge; start is held for exactly one rising edge.
   task automatic issue(input bit w3, input opcode_t op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] eo, input logic ee);
      int unsigned at;
      at = cyc + 1 + (((op == OP_MUL) || (op == OP_DIV)) ? (w3 ? 3 : 8) : 0);
      if (w3) begin
         a3 = a[2:0]; b3 = b[2:0]; op3 = op; st3 = 1'b1;
         q3.push_back('{eo, ee, at});
      end else begin
         a8 = a; b8 = b; op8 = op; st8 = 1'b1;
         q8.push_back('{eo, ee, at});
      end
      @(negedge clk);
      st8 = 1'b0;
      st3 = 1'b0;
   endtask

   task automatic wait_done(input bit w3, input int unsigned bound);
      int unsigned i = 0;
      while (!(w3 ? done3 : done8) && i < bound) begin
         @(negedge clk);
         i++;
      end
      if (!(w3 ? done3 : done8)) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: got no done within %0d cycles, expected done", bound);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int ndone;
      rst = 1'b1;
      st8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
      st3 = 1'b0; a3 = '0; b3 = '0; op3 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", {31'h0, busy8}, 32'h0);
      check("rst_done", {31'h0, done8}, 32'h0);
      check("rst_out",  {16'h0, out8},  32'h0);
      check("rst_err",  {31'h0, err8},  32'h0);

      issue(0, OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b0);
      check("add_busy", {31'h0, busy8}, 32'h0);
      wait_done(0, 4);
      @(negedge clk);

      issue(0, OP_SUB, 8'd5, 8'd7, 16'h01FE, 1'b0);
      wait_done(0, 4);
      @(negedge clk);

      issue(0, OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0);
      check("mul_busy", {31'h0, busy8}, 32'h1);
      a8 = 8'd1; b8 = 8'd1; op8 = OP_ADD; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      check("out_hold", {16'h0, out8}, 32'h01FE);
      wait_done(0, 16);
      @(negedge clk);

      issue(0, OP_DIV, 8'd100, 8'd7, 16'h020E, 1'b0);
      wait_done(0, 16);
      @(negedge clk);

      issue(0, OP_DIV, 8'd9, 8'd0, 16'h09FF, 1'b1);
      wait_done(0, 16);
      issue(0, OP_MUL, 8'd3, 8'd5, 16'h000F, 1'b0);
      wait_done(0, 16);
      issue(0, OP_MUL, 8'd16, 8'd16, 16'h0100, 1'b0);
      wait_done(0, 16);
      @(negedge clk);

      issue(0, OP_MUL, 8'd10, 8'd10, 16'd100, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'h0, busy8}, 32'h0);
      check("abort_out",  {16'h0, out8},  32'h0);
      check("abort_err",  {31'h0, err8},  32'h0);
      q8.delete();
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      check("abort_no_done", ndone, 32'h0);

      issue(1, OP_MUL, 8'd7, 8'd7, 16'd49, 1'b0);
      wait_done(1, 8);
      @(negedge clk);
      issue(1, OP_DIV, 8'd6, 8'd4, 16'd17, 1'b0);
      wait_done(1, 8);
      @(negedge clk);
      issue(1, OP_ADD, 8'd7, 8'd7, 16'd14, 1'b0);
      wait_done(1, 4);
      repeat (2) @(negedge clk);

      check("sb8_empty", q8.size(), 32'h0);
      check("sb3_empty", q3.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
